fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and hazard controller that supersedes the purely combinational forwarding unit. It keeps its own shadow pipeline of destination tags for the EX, MEM and WB stages. It generates registered EX-stage operand selects and combinational ID-stage (branch compare) selects for NUM_RD_PORTS source operands, and owns the load-use and branch stall state machine. It sits beside the ID/EX pipeline registers and drives the operand muxes and the PC/IF-ID write enable.

---
 rtl/fwd_pkg.sv | 27 ++
 rtl/fwd_port_match.sv | 65 ++++++
 rtl/fwd_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard controller: operand select codes,
// stall FSM states and the shadow-pipeline destination tag.
package fwd_pkg;

  // Widest register address the shadow tags can carry; narrower addresses are zero-extended.
  localparam int TAG_DST_W = 8;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  typedef struct packed {
    logic                 v;
    logic [TAG_DST_W-1:0] dst;
    logic                 ld;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/fwd_port_match.sv
// Hazard and forwarding decision for one source operand against the
// EX, MEM and WB shadow tags.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter bit BRANCH_IN_ID = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic                  use_i,
  input  logic                  branch_i,
  input  tag_t                  s_ex_i,
  input  tag_t                  s_mem_i,
  input  logic                  s_wb_v_i,
  input  logic [TAG_DST_W-1:0]  s_wb_dst_i,
  output logic [1:0]            need_o,
  output fwd_sel_t              ex_sel_next_o,
  output fwd_sel_t              id_sel_o
);

  logic [TAG_DST_W-1:0] addr_ext;
  logic                 live;
  logic                 is_branch;
  logic                 ex_hit;
  logic                 mem_hit;
  logic                 wb_hit;

  assign addr_ext  = TAG_DST_W'(addr_i);
  assign live      = use_i && (addr_i != '0);
  assign is_branch = branch_i && BRANCH_IN_ID;
  assign ex_hit    = live && s_ex_i.v  && (s_ex_i.dst  == addr_ext);
  assign mem_hit   = live && s_mem_i.v && (s_mem_i.dst == addr_ext);
  assign wb_hit    = live && s_wb_v_i  && (s_wb_dst_i  == addr_ext);

  always_comb begin
    need_o = 2'd0;
    if (ex_hit && s_ex_i.ld) begin
      need_o = is_branch ? 2'd2 : 2'd1;
    end else if (ex_hit) begin
      need_o = is_branch ? 2'd1 : 2'd0;
    end else if (mem_hit && s_mem_i.ld) begin
      need_o = is_branch ? 2'd1 : 2'd0;
    end
  end

  // Youngest producer wins; a loaded value is never taken from the EX/MEM latch in ID.
  always_comb begin
    ex_sel_next_o = FWD_REG;
    if (ex_hit) begin
      ex_sel_next_o = FWD_EXMEM;
    end else if (mem_hit) begin
      ex_sel_next_o = FWD_MEMWB;
    end

    id_sel_o = FWD_REG;
    if (BRANCH_IN_ID) begin
      if (mem_hit && !s_mem_i.ld) begin
        id_sel_o = FWD_EXMEM;
      end else if (wb_hit) begin
        id_sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: shadow destination pipeline, registered EX
// operand selects, combinational ID compare selects and the stall FSM.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_RD_PORTS = 2,
  parameter bit BRANCH_IN_ID = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               hold_i,
  input  logic                               flush_i,
  input  logic                               id_valid_i,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_src_addr_i,
  input  logic [NUM_RD_PORTS-1:0]            id_src_use_i,
  input  logic                               id_branch_i,
  input  logic [REG_ADDR_W-1:0]              id_dst_i,
  input  logic                               id_regwrite_i,
  input  logic                               id_memread_i,
  output logic                               stall_o,
  output logic [2*NUM_RD_PORTS-1:0]          ex_fwd_sel_o,
  output logic [2*NUM_RD_PORTS-1:0]          id_fwd_sel_o
);

  state_t                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  tag_t                      s_ex_q, s_ex_d;
  tag_t                      s_mem_q, s_mem_d;
  // WB only ever feeds ID forwarding, where the load flag no longer matters.
  logic                      s_wb_v_q, s_wb_v_d;
  logic [TAG_DST_W-1:0]      s_wb_dst_q, s_wb_dst_d;
  logic [2*NUM_RD_PORTS-1:0] ex_sel_q, ex_sel_d;

  logic [1:0] port_need   [NUM_RD_PORTS];
  fwd_sel_t   port_ex_sel [NUM_RD_PORTS];
  fwd_sel_t   port_id_sel [NUM_RD_PORTS];
  logic [1:0] need;
  logic       bubble;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    fwd_port_match #(
      .REG_ADDR_W   (REG_ADDR_W),
      .BRANCH_IN_ID (BRANCH_IN_ID)
    ) u_match (
      .addr_i        (id_src_addr_i[p*REG_ADDR_W +: REG_ADDR_W]),
      .use_i         (id_src_use_i[p]),
      .branch_i      (id_branch_i),
      .s_ex_i        (s_ex_q),
      .s_mem_i       (s_mem_q),
      .s_wb_v_i      (s_wb_v_q),
      .s_wb_dst_i    (s_wb_dst_q),
      .need_o        (port_need[p]),
      .ex_sel_next_o (port_ex_sel[p]),
      .id_sel_o      (port_id_sel[p])
    );
    assign id_fwd_sel_o[2*p +: 2] = port_id_sel[p];
  end

  always_comb begin
    need = 2'd0;
    if (id_valid_i) begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (port_need[p] > need) begin
          need = port_need[p];
        end
      end
    end
  end

  assign stall_o      = (state_q == STALL) || (need != 2'd0);
  assign bubble       = stall_o || flush_i || !id_valid_i;
  assign ex_fwd_sel_o = ex_sel_q;

  // The RUN cycle that detects a hazard is itself the first stall cycle, so
  // STALL only has to cover whatever is still owed beyond it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s_ex_d     = s_ex_q;
    s_mem_d    = s_mem_q;
    s_wb_v_d   = s_wb_v_q;
    s_wb_dst_d = s_wb_dst_q;
    ex_sel_d   = ex_sel_q;
    if (!hold_i) begin
      s_wb_v_d   = s_mem_q.v;
      s_wb_dst_d = s_mem_q.dst;
      s_mem_d    = s_ex_q;
      s_ex_d     = TAG_BUBBLE;
      if (!bubble) begin
        s_ex_d.v   = id_regwrite_i;
        s_ex_d.dst = TAG_DST_W'(id_dst_i);
        s_ex_d.ld  = id_memread_i;
      end
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        ex_sel_d[2*p +: 2] = bubble ? FWD_REG : port_ex_sel[p];
      end
      if (flush_i) begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end else begin
        case (state_q)
          RUN: begin
            if (need > 2'd1) begin
              state_d = STALL;
              cnt_d   = need - 2'd1;
            end
          end
          STALL: begin
            if (cnt_q > 2'd1) begin
              cnt_d = cnt_q - 2'd1;
            end else begin
              state_d = RUN;
              cnt_d   = 2'd0;
            end
          end
          default: begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= 2'd0;
      s_ex_q     <= TAG_BUBBLE;
      s_mem_q    <= TAG_BUBBLE;
      s_wb_v_q   <= 1'b0;
      s_wb_dst_q <= '0;
      ex_sel_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_ex_q     <= s_ex_d;
      s_mem_q    <= s_mem_d;
      s_wb_v_q   <= s_wb_v_d;
      s_wb_dst_q <= s_wb_dst_d;
      ex_sel_q   <= ex_sel_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: instruction sequences with hand-derived
// stall and select values, checked by immediate assertions.
module tb_fwd_hazard_ctrl;

  localparam int AW = 5;
  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            hold_i;
  logic            flush_i;
  logic            id_valid_i;
  logic [NP*AW-1:0] id_src_addr_i;
  logic [NP-1:0]   id_src_use_i;
  logic            id_branch_i;
  logic [AW-1:0]   id_dst_i;
  logic            id_regwrite_i;
  logic            id_memread_i;
  logic            stall_o;
  logic [2*NP-1:0] ex_fwd_sel_o;
  logic [2*NP-1:0] id_fwd_sel_o;

  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .REG_ADDR_W   (AW),
    .NUM_RD_PORTS (NP),
    .BRANCH_IN_ID (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hold_i        (hold_i),
    .flush_i       (flush_i),
    .id_valid_i    (id_valid_i),
    .id_src_addr_i (id_src_addr_i),
    .id_src_use_i  (id_src_use_i),
    .id_branch_i   (id_branch_i),
    .id_dst_i      (id_dst_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .stall_o       (stall_o),
    .ex_fwd_sel_o  (ex_fwd_sel_o),
    .id_fwd_sel_o  (id_fwd_sel_o)
  );

  task automatic applyStimulus(input logic valid, input logic [AW-1:0] src0,
                               input logic [AW-1:0] src1, input logic [1:0] useMask,
                               input logic branch, input logic [AW-1:0] dst,
                               input logic regWrite, input logic memRead);
    id_valid_i    = valid;
    id_src_addr_i = {src1, src0};
    id_src_use_i  = useMask;
    id_branch_i   = branch;
    id_dst_i      = dst;
    id_regwrite_i = regWrite;
    id_memread_i  = memRead;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic idleCycles(input int n);
    applyIdle();
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic expStall,
                             input logic [2*NP-1:0] expEx, input logic [2*NP-1:0] expId);
    checkCount++;
    assert (stall_o === expStall) else begin
      errorCount++;
      $error("[TB] FAIL %s stall_o got %b want %b", name, stall_o, expStall);
    end
    checkCount++;
    assert (ex_fwd_sel_o === expEx) else begin
      errorCount++;
      $error("[TB] FAIL %s ex_fwd_sel_o got %b want %b", name, ex_fwd_sel_o, expEx);
    end
    checkCount++;
    assert (id_fwd_sel_o === expId) else begin
      errorCount++;
      $error("[TB] FAIL %s id_fwd_sel_o got %b want %b", name, id_fwd_sel_o, expId);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset   = 1'b1;
    hold_i  = 1'b0;
    flush_i = 1'b0;
    applyIdle();
    repeat (2) @(negedge clk);
    #1 checkOutput("reset", 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // ALU producer immediately followed by its consumer
    applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 5'd3, 1'b1, 1'b0);
    #1 checkOutput("alu_add", 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    applyStimulus(1'b1, 5'd3, 5'd4, 2'b11, 1'b0, 5'd5, 1'b1, 1'b0);
    #1 checkOutput("alu_sub_id", 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    applyIdle();
    #1 checkOutput("alu_b2b_ex", 1'b0, 4'b0001, 4'b0000);
    idleCycles(3);

    // One-instruction gap between producer and consumer
    applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    applyIdle();
    @(negedge clk);
    applyStimulus(1'b1, 5'd3, 5'd4, 2'b11, 1'b0, 5'd5, 1'b1, 1'b0);
    #1 checkOutput("gap_id", 1'b0, 4'b0000, 4'b0001);
    @(negedge clk);
    applyIdle();
    #1 checkOutput("gap_ex", 1'b0, 4'b0010, 4'b0000);
    idleCycles(3);

    // Load-use: exactly one stall cycle, then MEM/WB forwarding
    applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 1'b0, 5'd2, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 5'd2, 5'd7, 2'b11, 1'b0, 5'd6, 1'b1, 1'b0);
    #1 checkOutput("ldu_stall", 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    #1 checkOutput("ldu_release", 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    applyIdle();
    #1 checkOutput("ldu_ex", 1'b0, 4'b0010, 4'b0000);
    idleCycles(3);

    // Branch compare after a load: two stall cycles, then ID takes MEM/WB
    applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 1'b0, 5'd4, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 5'd4, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("brld_stall1", 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    #1 checkOutput("brld_stall2", 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    #1 checkOutput("brld_go", 1'b0, 4'b0000, 4'b0010);
    idleCycles(3);

    // Branch compare after an ALU write: one stall cycle, then ID takes EX/MEM
    applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 5'd4, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 5'd4, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("bralu_stall", 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    #1 checkOutput("bralu_go", 1'b0, 4'b0000, 4'b0001);
    idleCycles(3);

    // Register 0 is never stalled on or forwarded
    applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 1'b0, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("r0_nostall", 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 5'd5, 1'b1, 1'b0);
    #1 checkOutput("r0_id", 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    applyIdle();
    #1 checkOutput("r0_ex", 1'b0, 4'b0000, 4'b0000);
    idleCycles(3);

    // Each port matches a different stage
    applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 5'd8, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 5'd9, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 5'd8, 5'd9, 2'b11, 1'b0, 5'd10, 1'b1, 1'b0);
    #1 checkOutput("dual_id", 1'b0, 4'b0000, 4'b0001);
    @(negedge clk);
    applyIdle();
    #1 checkOutput("dual_ex", 1'b0, 4'b0110, 4'b0000);
    idleCycles(3);

    // Same register written twice: youngest writer wins on both ports
    applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 5'd11, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 5'd11, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 5'd11, 5'd11, 2'b11, 1'b0, 5'd12, 1'b1, 1'b0);
    #1 checkOutput("same_id", 1'b0, 4'b0000, 4'b0101);
    @(negedge clk);
    applyIdle();
    #1 checkOutput("same_ex", 1'b0, 4'b0101, 4'b0000);
    idleCycles(3);

    // Hold for three cycles in the middle of a two-cycle branch stall
    applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 1'b0, 5'd4, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 5'd4, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("hold_pre", 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    hold_i = 1'b1;
    #1 checkOutput("hold_0", 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    flush_i = 1'b1;
    #1 checkOutput("hold_1", 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    flush_i = 1'b0;
    #1 checkOutput("hold_2", 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    hold_i = 1'b0;
    #1 checkOutput("hold_release", 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    #1 checkOutput("hold_done", 1'b0, 4'b0000, 4'b0010);
    idleCycles(3);

    // A flushed ID instruction must not reach the shadow pipeline
    applyStimulus(1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 5'd12, 1'b1, 1'b0);
    flush_i = 1'b1;
    #1 checkOutput("flush_in", 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    flush_i = 1'b0;
    applyStimulus(1'b1, 5'd12, 5'd0, 2'b01, 1'b0, 5'd13, 1'b1, 1'b0);
    @(negedge clk);
    applyIdle();
    #1 checkOutput("flush_bubble", 1'b0, 4'b0000, 4'b0000);
    idleCycles(3);

    // Flush during a branch stall returns straight to RUN
    applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 1'b0, 5'd4, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 5'd4, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 1'b0);
    flush_i = 1'b1;
    #1 checkOutput("brflush_stall", 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    flush_i = 1'b0;
    applyIdle();
    #1 checkOutput("brflush_run", 1'b0, 4'b0000, 4'b0000);
    idleCycles(3);

    // Asynchronous reset while in STALL clears outputs without a clock edge
    applyStimulus(1'b1, 5'd1, 5'd0, 2'b01, 1'b0, 5'd4, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 5'd4, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("rst_pre", 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    #1 checkOutput("rst_in_stall", 1'b1, 4'b0000, 4'b0000);
    #1 reset = 1'b1;
    #1 checkOutput("rst_async", 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    applyIdle();
    #1 checkOutput("post_rst", 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
